// File: rtl/snitch_dreq_reorder.sv
// Tags LSU data requests with a slot ID and retires out-of-order memory responses
// back to the core in issue order.

package snitch_dreq_reorder_pkg;

   localparam int unsigned MetaIdWidth = 3;
   localparam int unsigned PkgDataWidth = 32;

   typedef logic [MetaIdWidth-1:0] meta_id_t;

   typedef struct packed {
      logic [31:0]             addr;
      logic                    write;
      logic [PkgDataWidth-1:0] data;
      logic [3:0]              strb;
      meta_id_t                id;
   } dreq_t;

   typedef struct packed {
      logic [PkgDataWidth-1:0] data;
      logic                    write;
      logic                    error;
      meta_id_t                id;
   } dresp_t;

   function automatic int unsigned idx_width(input int unsigned num);
      return (num > 1) ? $clog2(num) : 1;
   endfunction

endpackage

module snitch_dreq_reorder
   import snitch_dreq_reorder_pkg::*;
#(
   parameter int unsigned NumOutstanding = 8,
   parameter int unsigned IdWidth        = idx_width(NumOutstanding),
   parameter int unsigned DataWidth      = 32
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  dreq_t  core_req_i,
   input  logic   core_req_valid_i,
   output logic   core_req_ready_o,
   output dresp_t core_resp_o,
   output logic   core_resp_valid_o,
   input  logic   core_resp_ready_i,
   output dreq_t  mem_req_o,
   output logic   mem_req_valid_o,
   input  logic   mem_req_ready_i,
   input  dresp_t mem_resp_i,
   input  logic   mem_resp_valid_i,
   output logic   empty_o
);

   localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
   localparam logic [CntWidth-1:0] CntMax  = CntWidth'(NumOutstanding);
   localparam logic [IdWidth-1:0]  LastIdx = IdWidth'(NumOutstanding - 1);

   logic [IdWidth-1:0]  head_q, tail_q;
   logic [CntWidth-1:0] cnt_q;

   logic [NumOutstanding-1:0]                busy_q, done_q;
   logic [NumOutstanding-1:0][DataWidth-1:0] data_q;
   logic [NumOutstanding-1:0]                write_q, error_q;

   logic full, alloc, retire;

   // Full blocks issue outright; a same-cycle retire is deliberately not forwarded.
   assign full             = (cnt_q == CntMax);
   assign core_req_ready_o = mem_req_ready_i && !full;
   assign mem_req_valid_o  = core_req_valid_i && !full;
   assign alloc            = core_req_valid_i && core_req_ready_o;

   assign core_resp_valid_o = busy_q[head_q] && done_q[head_q];
   assign retire            = core_resp_valid_o && core_resp_ready_i;
   assign empty_o           = (cnt_q == '0);

   // NOTE: every always_comb output gets a full default first, so no latch can be inferred.
   always_comb begin
      mem_req_o    = core_req_i;
      mem_req_o.id = tail_q;
   end

   always_comb begin
      core_resp_o       = '0;
      core_resp_o.data  = data_q[head_q];
      core_resp_o.write = write_q[head_q];
      core_resp_o.error = error_q[head_q];
      core_resp_o.id    = head_q;
   end

   // NOTE: non-blocking assignments throughout, so allocate/complete/retire all see pre-edge state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= '0;
         done_q  <= '0;
         // NOTE: the payload array is reset as well so core_resp_o reads all-zero out of reset.
         data_q  <= '0;
         write_q <= '0;
         error_q <= '0;
      end else begin
         if (alloc) begin
            busy_q[tail_q] <= 1'b1;
            done_q[tail_q] <= 1'b0;
            tail_q         <= (tail_q == LastIdx) ? '0 : tail_q + IdWidth'(1);
         end

         if (mem_resp_valid_i) begin
            data_q[mem_resp_i.id]  <= mem_resp_i.data;
            write_q[mem_resp_i.id] <= mem_resp_i.write;
            error_q[mem_resp_i.id] <= mem_resp_i.error;
            done_q[mem_resp_i.id]  <= 1'b1;
         end

         // Head and tail never coincide here: that needs cnt 0 (no retire) or full (no alloc).
         if (retire) begin
            busy_q[head_q] <= 1'b0;
            done_q[head_q] <= 1'b0;
            head_q         <= (head_q == LastIdx) ? '0 : head_q + IdWidth'(1);
         end

         case ({alloc, retire})
            2'b10:   cnt_q <= cnt_q + CntWidth'(1);
            2'b01:   cnt_q <= cnt_q - CntWidth'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // A response must target an issued, still-pending slot.
   resp_to_pending_slot: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      mem_resp_valid_i |-> (busy_q[mem_resp_i.id] && !done_q[mem_resp_i.id])
   );

endmodule

// File: tb/tb_snitch_dreq_reorder.sv
// Directed bench for snitch_dreq_reorder: fill, out-of-order return, full+retire,
// backpressure, async reset and pointer wrap-around.

module tb_snitch_dreq_reorder;
   import snitch_dreq_reorder_pkg::*;

   logic   clk_i = 1'b0;
   logic   rst_ni;
   dreq_t  core_req;
   logic   core_req_valid, core_req_ready;
   dresp_t core_resp;
   logic   core_resp_valid, core_resp_ready;
   dreq_t  mem_req;
   logic   mem_req_valid, mem_req_ready;
   dresp_t mem_resp;
   logic   mem_resp_valid;
   logic   empty;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   snitch_dreq_reorder #(.NumOutstanding(8), .DataWidth(32)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .core_req_i        (core_req),
      .core_req_valid_i  (core_req_valid),
      .core_req_ready_o  (core_req_ready),
      .core_resp_o       (core_resp),
      .core_resp_valid_o (core_resp_valid),
      .core_resp_ready_i (core_resp_ready),
      .mem_req_o         (mem_req),
      .mem_req_valid_o   (mem_req_valid),
      .mem_req_ready_i   (mem_req_ready),
      .mem_resp_i        (mem_resp),
      .mem_resp_valid_i  (mem_resp_valid),
      .empty_o           (empty)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1ns later, well before the rising edge.
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic respond(input logic [2:0] id, input logic [31:0] data, input logic err);
      mem_resp_valid = 1'b1;
      mem_resp       = '0;
      mem_resp.id    = id;
      mem_resp.data  = data;
      mem_resp.error = err;
   endtask

   initial begin
      logic [2:0]  exp_id;
      logic [31:0] exp_data;

      rst_ni          = 1'b0;
      core_req        = '0;
      core_req_valid  = 1'b0;
      core_resp_ready = 1'b0;
      mem_req_ready   = 1'b1;
      mem_resp        = '0;
      mem_resp_valid  = 1'b0;

      // Reset state
      @(negedge clk_i);
      #1;
      check("rst_resp_valid", core_resp_valid, 0);
      check("rst_mreq_valid", mem_req_valid, 0);
      check("rst_resp_word", core_resp, 0);
      check("rst_empty", empty, 1);
      check("rst_ready_follow1", core_req_ready, 1);
      mem_req_ready = 1'b0;
      #1;
      check("rst_ready_follow0", core_req_ready, 0);
      mem_req_ready = 1'b1;
      tick();
      rst_ni = 1'b1;
      tick();

      // Fill all eight slots with loads
      for (int i = 0; i < 8; i++) begin
         core_req_valid = 1'b1;
         core_req       = '0;
         core_req.addr  = 32'h100 + 32'(i) * 4;
         core_req.id    = 3'd7 - 3'(i);
         #1;
         check("fill_mvalid", mem_req_valid, 1);
         check("fill_ready", core_req_ready, 1);
         check("fill_id", mem_req.id, 64'(i));
         check("fill_addr", mem_req.addr, 64'h100 + 64'(i) * 4);
         tick();
      end
      #1;
      check("full_ready", core_req_ready, 0);
      check("full_mvalid", mem_req_valid, 0);
      check("full_nonempty", empty, 0);
      core_req_valid = 1'b0;

      // Out-of-order return 3,1,0,2 -> core sees 0,1,2,3
      core_resp_ready = 1'b1;
      respond(3'd3, 32'h33, 1'b0);
      #1 check("ooo_wait3", core_resp_valid, 0);
      tick();
      respond(3'd1, 32'h11, 1'b0);
      #1 check("ooo_wait1", core_resp_valid, 0);
      tick();
      respond(3'd0, 32'h00, 1'b0);
      #1 check("ooo_same_cycle", core_resp_valid, 0);
      tick();
      respond(3'd2, 32'h22, 1'b0);
      #1;
      check("ooo_v0", core_resp_valid, 1);
      check("ooo_d0", core_resp.data, 32'h00);
      check("ooo_id0", core_resp.id, 0);
      tick();
      mem_resp_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         #1;
         check("ooo_v", core_resp_valid, 1);
         check("ooo_d", core_resp.data, 64'(i) * 64'h11);
         check("ooo_id", core_resp.id, 64'(i));
         tick();
      end
      #1 check("ooo_head4_wait", core_resp_valid, 0);

      // Refill to full (ids 0..3), then retire head while full
      for (int i = 0; i < 4; i++) begin
         core_req_valid = 1'b1;
         #1 check("refill_id", mem_req.id, 64'(i));
         tick();
      end
      core_resp_ready = 1'b0;
      respond(3'd4, 32'h44, 1'b0);
      #1 check("fr_stall0", core_req_ready, 0);
      tick();
      mem_resp_valid  = 1'b0;
      core_resp_ready = 1'b1;
      #1;
      check("fr_resp_valid", core_resp_valid, 1);
      check("fr_resp_data", core_resp.data, 32'h44);
      check("fr_stall_ready", core_req_ready, 0);
      check("fr_stall_mvalid", mem_req_valid, 0);
      tick();
      #1;
      check("fr_issue_valid", mem_req_valid, 1);
      check("fr_issue_id", mem_req.id, 4);
      tick();
      #1 check("fr_full_again", core_req_ready, 0);
      core_req_valid = 1'b0;

      // Backpressure on a done head
      core_resp_ready = 1'b0;
      respond(3'd5, 32'hDEADBEEF, 1'b1);
      tick();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", core_resp_valid, 1);
         check("bp_data", core_resp.data, 32'hDEADBEEF);
         check("bp_error", core_resp.error, 1);
         check("bp_id", core_resp.id, 5);
         tick();
      end
      core_resp_ready = 1'b1;
      #1 check("bp_release", core_resp.data, 32'hDEADBEEF);
      tick();
      #1;
      check("bp_once", core_resp_valid, 0);
      check("bp_slot_free", core_req_ready, 1);

      // Drain 6,7,0 returned as 0,7,6
      respond(3'd0, 32'hA0, 1'b0);
      #1 check("dr_wait0", core_resp_valid, 0);
      tick();
      respond(3'd7, 32'hA7, 1'b0);
      #1 check("dr_wait7", core_resp_valid, 0);
      tick();
      respond(3'd6, 32'hA6, 1'b0);
      #1 check("dr_wait6", core_resp_valid, 0);
      tick();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_id = 3'd6 + 3'(i);
         #1;
         check("dr_valid", core_resp_valid, 1);
         check("dr_id", core_resp.id, 64'(exp_id));
         check("dr_data", core_resp.data, 64'h0A0 + 64'(exp_id));
         tick();
      end
      #1 check("dr_left4", core_resp_valid, 0);

      // Async reset with slots 1..4 outstanding and head 1 presenting
      core_resp_ready = 1'b0;
      respond(3'd1, 32'hB1, 1'b0);
      tick();
      mem_resp_valid = 1'b0;
      #1 check("ar_pre_valid", core_resp_valid, 1);
      #1 rst_ni = 1'b0;
      #1;
      check("ar_valid", core_resp_valid, 0);
      check("ar_empty", empty, 1);
      check("ar_resp_word", core_resp, 0);
      @(negedge clk_i);
      tick();
      rst_ni = 1'b1;
      core_resp_ready = 1'b1;

      // Wrap-around: 20 single requests, each answered right away
      for (int k = 0; k < 20; k++) begin
         exp_id   = 3'(k % 8);
         exp_data = 32'h1000 + 32'(k);
         core_req_valid = 1'b1;
         #1 check("wr_issue_id", mem_req.id, 64'(exp_id));
         tick();
         core_req_valid = 1'b0;
         respond(exp_id, exp_data, 1'b0);
         #1 check("wr_not_yet", core_resp_valid, 0);
         tick();
         mem_resp_valid = 1'b0;
         #1;
         check("wr_valid", core_resp_valid, 1);
         check("wr_data", core_resp.data, 64'(exp_data));
         check("wr_id", core_resp.id, 64'(exp_id));
         tick();
      end
      #1;
      check("wr_empty", empty, 1);
      check("wr_idle", core_resp_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
